// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out transmitter.
//   piso_state_t : two-state frame FSM encoding
//   cnt_width()  : bit-counter width for a given word width (never below 1)
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  // Width of a counter that must hold 0..w-1.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Loadable shift register holding the bits of a word still to be sent.
//   clk, reset : clock, async active-high reset
//   load       : capture load_data (the bit sent first is dropped, it goes
//                straight to the output register in the parent)
//   shift_en   : advance by one bit, zero fill
//   load_data  : parallel word
//   first_bit  : bit of load_data that is transmitted first
//   tap        : bit that will be transmitted after the current one
module piso_shift_reg #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] load_data,
  output logic             first_bit,
  output logic             tap
);

  logic [WIDTH-1:0] q;

  assign first_bit = LSB_FIRST ? load_data[0] : load_data[WIDTH-1];
  assign tap       = LSB_FIRST ? q[0] : q[WIDTH-1];

  // Loaded pre-shifted by one so tap always presents the following bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= LSB_FIRST ? (load_data >> 1) : (load_data << 1);
    end else if (shift_en) begin
      q <= LSB_FIRST ? (q >> 1) : (q << 1);
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter with valid/ready input and frame strobes.
//   clk, reset : clock, async active-high reset
//   in_data    : parallel word, sampled on accept (in_valid & in_ready)
//   in_valid   : in_data valid
//   in_ready   : can accept this cycle (combinational)
//   ser_out    : serial data bit (registered)
//   ser_valid  : ser_out carries a frame bit (registered)
//   ser_first  : first bit of a frame (registered)
//   ser_last   : last bit of a frame (registered)
//   busy       : frame in progress, equal to ser_valid (registered)
module piso_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
);

  import piso_pkg::*;

  localparam int unsigned   CW         = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_PENULT = CW'(WIDTH - 2);

  piso_state_t   state;
  piso_state_t   state_nxt;
  logic [CW-1:0] bit_cnt;
  logic [CW-1:0] bit_cnt_nxt;

  logic accept;
  logic at_last;
  logic shift_en;
  logic first_bit;
  logic tap;
  logic ser_out_nxt;
  logic ser_valid_nxt;
  logic ser_first_nxt;
  logic ser_last_nxt;

  piso_shift_reg #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_shift_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .shift_en  (shift_en),
    .load_data (in_data),
    .first_bit (first_bit),
    .tap       (tap)
  );

  // State and bit counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
    end
  end

  // Next state: a new word may only be taken in IDLE or on the last bit.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (at_last && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake, shift control and next values of the registered outputs.
  always_comb begin
    at_last       = (state == SHIFT) && (bit_cnt == CNT_LAST);
    in_ready      = (state == IDLE) || at_last;
    accept        = in_valid && in_ready;
    shift_en      = (state == SHIFT) && !at_last;
    bit_cnt_nxt   = '0;
    ser_out_nxt   = 1'b0;
    ser_valid_nxt = accept || shift_en;
    ser_first_nxt = accept;
    ser_last_nxt  = shift_en && (bit_cnt == CNT_PENULT);
    if (shift_en) begin
      bit_cnt_nxt = bit_cnt + CW'(1);
    end
    if (accept) begin
      ser_out_nxt = first_bit;
    end else if (shift_en) begin
      ser_out_nxt = tap;
    end
  end

  // Output registers: the first bit leaves on the accepting edge itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      ser_first <= 1'b0;
      ser_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      ser_out   <= ser_out_nxt;
      ser_valid <= ser_valid_nxt;
      ser_first <= ser_first_nxt;
      ser_last  <= ser_last_nxt;
      busy      <= ser_valid_nxt;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: one MSB-first and one LSB-first instance (WIDTH=8).
// Words are sent from a table; expected serial bits are queued when a word is
// accepted and compared by per-instance monitors on the falling edge.
module tb_piso_serializer;

  typedef struct {
    logic b;
    logic f;
    logic l;
  } exp_t;

  typedef struct {
    bit         lsb;
    logic [7:0] data;
    logic [7:0] seq;   // expected bits in transmit order, leftmost first
    int         gap;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] m_data = '0;
  logic       m_valid = 1'b0;
  logic       m_ready, m_so, m_sv, m_sf, m_sl, m_busy;
  logic [7:0] l_data = '0;
  logic       l_valid = 1'b0;
  logic       l_ready, l_so, l_sv, l_sf, l_sl, l_busy;

  int   checks = 0;
  int   errors = 0;
  int   run[2];
  int   max_run[2];
  exp_t q_m[$];
  exp_t q_l[$];
  vec_t vecs[7];

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .reset(reset), .in_data(m_data), .in_valid(m_valid),
    .in_ready(m_ready), .ser_out(m_so), .ser_valid(m_sv),
    .ser_first(m_sf), .ser_last(m_sl), .busy(m_busy)
  );

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .reset(reset), .in_data(l_data), .in_valid(l_valid),
    .in_ready(l_ready), .ser_out(l_so), .ser_valid(l_sv),
    .ser_first(l_sf), .ser_last(l_sl), .busy(l_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? l_ready : m_ready;
  endfunction

  function automatic logic sv(input bit sel);
    return sel ? l_sv : m_sv;
  endfunction

  task automatic drive(input bit sel, input logic v, input logic [7:0] d);
    if (sel) begin
      l_valid = v;
      l_data  = d;
    end else begin
      m_valid = v;
      m_data  = d;
    end
  endtask

  task automatic push(input bit sel, input logic [7:0] seq);
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      e.b = seq[7-k];
      e.f = (k == 0);
      e.l = (k == 7);
      if (sel) q_l.push_back(e);
      else     q_m.push_back(e);
    end
  endtask

  // Per-cycle output check for one instance.
  task automatic mon(input bit sel, input logic so, input logic v, input logic sf,
                     input logic sl, input logic bz, input logic rd);
    exp_t e;
    int   n;
    chk(sel ? "l_busy_eq_valid" : "m_busy_eq_valid", bz, v);
    chk(sel ? "l_ready_rule" : "m_ready_rule", rd, !v || sl);
    if (v) begin
      run[sel]++;
      if (run[sel] > max_run[sel]) max_run[sel] = run[sel];
      n = sel ? q_l.size() : q_m.size();
      chk(sel ? "l_bit_expected" : "m_bit_expected", n != 0, 1);
      if (n != 0) begin
        e = sel ? q_l.pop_front() : q_m.pop_front();
        chk(sel ? "l_ser_out" : "m_ser_out", so, e.b);
        chk(sel ? "l_ser_first" : "m_ser_first", sf, e.f);
        chk(sel ? "l_ser_last" : "m_ser_last", sl, e.l);
      end
    end else begin
      run[sel] = 0;
      chk(sel ? "l_idle_outputs" : "m_idle_outputs", {so, sf, sl}, 3'b000);
    end
  endtask

  always @(negedge clk) mon(1'b0, m_so, m_sv, m_sf, m_sl, m_busy, m_ready);
  always @(negedge clk) mon(1'b1, l_so, l_sv, l_sf, l_sl, l_busy, l_ready);

  // Offer a word until accepted; junk=1 scrambles in_data while not ready.
  task automatic send_word(input bit sel, input logic [7:0] d, input logic [7:0] seq,
                           input bit junk);
    int waited = 0;
    bit done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (rdy(sel)) begin
        drive(sel, 1'b1, d);
        push(sel, seq);
        done = 1'b1;
      end else begin
        drive(sel, 1'b1, junk ? 8'($urandom) : d);
        waited++;
        if (waited > 60) begin
          chk("accept_timeout", 0, 1);
          drive(sel, 1'b0, '0);
          return;
        end
      end
    end
    @(posedge clk);
    #1;
    chk(sel ? "l_first_latency" : "m_first_latency",
        sel ? {l_sv, l_sf} : {m_sv, m_sf}, 2'b11);
  endtask

  // Drop in_valid, let the frame finish, then hold idle for n cycles.
  task automatic idle(input bit sel, input int n);
    int w = 0;
    @(negedge clk);
    drive(sel, 1'b0, '0);
    while (sv(sel) && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("frame_end_timeout", w < 40, 1);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    run[0] = 0; run[1] = 0; max_run[0] = 0; max_run[1] = 0;
    vecs[0] = '{1'b0, 8'hA5, 8'hA5, 3};
    vecs[1] = '{1'b0, 8'hA5, 8'hA5, 0};
    vecs[2] = '{1'b0, 8'h3C, 8'h3C, 5};
    vecs[3] = '{1'b1, 8'h01, 8'h80, 2};
    vecs[4] = '{1'b1, 8'h80, 8'h01, 0};
    vecs[5] = '{1'b1, 8'hC8, 8'h13, 2};
    vecs[6] = '{1'b0, 8'h81, 8'h81, 1};

    // Reset state
    #12;
    chk("rst_outputs", {m_so, m_sv, m_sf, m_sl, m_busy}, 5'b0);
    chk("rst_ready", {m_ready, l_ready}, 2'b11);
    @(negedge clk);
    reset = 1'b0;

    // Table: single words, back-to-back pairs, idle gaps, both bit orders
    for (int i = 0; i < 7; i++) begin
      send_word(vecs[i].lsb, vecs[i].data, vecs[i].seq, 1'b0);
      if (vecs[i].gap > 0) idle(vecs[i].lsb, vecs[i].gap);
    end
    repeat (12) @(posedge clk);
    chk("m_contiguous_run", max_run[0], 16);
    chk("l_contiguous_run", max_run[1], 16);

    // in_data scrambled while not ready: only the last-bit word is taken
    send_word(1'b0, 8'h96, 8'h96, 1'b1);
    send_word(1'b0, 8'h4B, 8'h4B, 1'b1);
    idle(1'b0, 2);

    // Reset during bit 3 of 0xFF aborts the frame immediately
    send_word(1'b0, 8'hFF, 8'hFF, 1'b0);
    m_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_abort_bit", {m_sv, m_so}, 2'b11);
    reset = 1'b1;
    #1;
    chk("abort_outputs", {m_so, m_sv, m_sf, m_sl, m_busy}, 5'b0);
    chk("abort_ready", m_ready, 1);
    q_m.delete();
    q_l.delete();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_reset_ready", m_ready, 1);
    send_word(1'b0, 8'h81, 8'h81, 1'b0);
    idle(1'b0, 3);

    repeat (4) @(posedge clk);
    chk("m_queue_drained", q_m.size(), 0);
    chk("l_queue_drained", q_l.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
